bcd_to_bin: RTL

Sequential packed-BCD to binary converter, the inverse of the design's combinational binary-to-BCD block. It accepts an 8-digit packed BCD word (up to 99,999,999) and returns the equivalent unsigned binary value. It processes one decimal digit per clock, most significant digit first, using the recurrence acc = acc*10 + digit. It sits between the display/keypad-side decimal logic and the arithmetic datapath, with a start/busy/done handshake.

---
 rtl/bcd_to_bin.sv | 84 ++++++++
 1 files changed

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential packed-BCD to binary converter, one digit per clock
module bcd_to_bin #(
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [31:0]           binary,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic {IDLE, CONV} state_t;

  // Digit counter is 4 bits so DIGITS up to 9 fits without a zero-width vector at DIGITS=1.
  localparam logic [3:0] LAST = 4'(DIGITS - 1);

  state_t              state;
  logic [4*DIGITS-1:0] sr;
  logic [31:0]         acc;
  logic [3:0]          cnt;
  logic                bad;

  logic                any_bad;
  logic [31:0]         acc_next;

  // Flag any non-decimal nibble in the operand being offered for capture.
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) any_bad = 1'b1;
    end
  end

  // acc*10 + next digit, using shifts; the top nibble of sr is the current digit.
  always_comb begin
    acc_next = (acc << 3) + (acc << 1) + {28'd0, sr[4*DIGITS-1 -: 4]};
  end

  assign busy = (state == CONV);

  // Conversion FSM: capture in IDLE, accumulate one digit per cycle in CONV.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sr     <= '0;
      acc    <= '0;
      cnt    <= '0;
      bad    <= 1'b0;
      binary <= '0;
      done   <= 1'b0;
      error  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= bcd;
            acc   <= '0;
            cnt   <= '0;
            bad   <= any_bad;
            state <= CONV;
          end
        end
        CONV: begin
          acc <= acc_next;
          sr  <= sr << 4;
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
            // Invalid digits still flowed through acc; only bad decides the result.
            binary <= bad ? 32'd0 : acc_next;
            error  <= bad;
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
